countdown_timer_8_bit: RTL and testbench

COUNTDOWN_TIMER_8_BIT -- requirements
Module: countdown_timer_8_bit

---
 rtl/countdown_timer_8_bit.sv | 109 ++++++++++
 tb/tb_countdown_timer_8_bit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer_8_bit.sv
// 8-bit countdown timer with load/start/pause control and a one-cycle borrow pulse at zero.
// Define COUNTDOWN_AUTORELOAD_EN to reload from the reload register at zero instead of stopping in DONE.
module countdown_timer_8_bit (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       load_in,
  input  logic       start_in,
  input  logic       pause_in,
  input  logic [7:0] limit,
  output logic [7:0] out,
  output logic       borrow,
  output logic       busy,
  output logic       done,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] count_q, count_d;
  logic [7:0] reload_q, reload_d;
  logic       borrow_q, borrow_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      count_q  <= 8'd0;
      reload_q <= 8'd0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Priority per edge: load, then start, then pause, then decrement.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    borrow_d = 1'b0;
    if (load_in) begin
      count_d  = limit;
      reload_d = limit;
      state_d  = IDLE;
    end else if (start_in) begin
      if (reload_q != 8'd0) begin
        count_d = reload_q;
        state_d = RUN;
      end else begin
        count_d = 8'd0;
        state_d = IDLE;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (pause_in) begin
            state_d = PAUSE;
          end else if (count_q == 8'd1) begin
            borrow_d = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
            count_d  = reload_q;
`else
            count_d  = 8'd0;
            state_d  = DONE;
`endif
          end else if (count_q != 8'd0) begin
            count_d = count_q - 8'd1;
          end else begin
            // Unreachable in normal operation; park safely without a borrow.
`ifdef COUNTDOWN_AUTORELOAD_EN
            state_d = IDLE;
`else
            state_d = DONE;
`endif
          end
        end
        PAUSE: begin
          if (!pause_in) state_d = RUN;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
    busy_d = (state_d == RUN) || (state_d == PAUSE);
    done_d = (state_d == DONE);
  end

  assign out     = count_q;
  assign borrow  = borrow_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_countdown_timer_8_bit.sv
// Directed self-checking bench for countdown_timer_8_bit (default build, auto-reload disabled).
module tb_countdown_timer_8_bit;

  logic       clk_in;
  logic       rst_in;
  logic       load_in;
  logic       start_in;
  logic       pause_in;
  logic [7:0] limit;
  logic [7:0] out;
  logic       borrow;
  logic       busy;
  logic       done;
  logic [1:0] state_o;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  int checks = 0;
  int errors = 0;

  countdown_timer_8_bit dut (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .load_in (load_in),
    .start_in(start_in),
    .pause_in(pause_in),
    .limit   (limit),
    .out     (out),
    .borrow  (borrow),
    .busy    (busy),
    .done    (done),
    .state_o (state_o)
  );

  // Clock and reset
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Driver tasks
  task automatic do_load(input logic [7:0] val);
    limit = val; load_in = 1'b1;
    tick();
    load_in = 1'b0;
  endtask

  task automatic do_start();
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1; load_in = 1'b0; start_in = 1'b0; pause_in = 1'b0; limit = 8'd0;
    tick();
    checks++; if (out !== 8'd0) begin errors++; $display("FAIL reset_out got=%0d exp=0", out); end
    checks++; if ({borrow, busy, done} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {borrow, busy, done}); end
    checks++; if (state_o !== ST_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", state_o, ST_IDLE); end
    #3 rst_in = 1'b0;
    tick();
    checks++; if (state_o !== ST_IDLE || out !== 8'd0) begin errors++; $display("FAIL post_reset_idle state=%0d out=%0d exp state=0 out=0", state_o, out); end
  endtask

  task automatic test_basic_countdown();
    do_load(8'd5);
    checks++; if (out !== 8'd5 || state_o !== ST_IDLE || busy !== 1'b0) begin errors++; $display("FAIL basic_load out=%0d state=%0d busy=%b exp 5/0/0", out, state_o, busy); end
    do_start();
    checks++; if (out !== 8'd5 || state_o !== ST_RUN || busy !== 1'b1) begin errors++; $display("FAIL basic_start out=%0d state=%0d busy=%b exp 5/1/1", out, state_o, busy); end
    for (int exp_v = 4; exp_v >= 0; exp_v--) begin
      tick();
      checks++; if (out !== exp_v[7:0]) begin errors++; $display("FAIL basic_count got=%0d exp=%0d", out, exp_v); end
      checks++; if (borrow !== (exp_v == 0)) begin errors++; $display("FAIL basic_borrow out=%0d got=%b exp=%b", out, borrow, (exp_v == 0)); end
      checks++; if (done !== (exp_v == 0)) begin errors++; $display("FAIL basic_done out=%0d got=%b exp=%b", out, done, (exp_v == 0)); end
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({borrow, done, busy} !== 3'b010 || out !== 8'd0 || state_o !== ST_DONE) begin
        errors++; $display("FAIL basic_hold borrow/done/busy=%b out=%0d state=%0d exp 010/0/3", {borrow, done, busy}, out, state_o);
      end
    end
    // Restart from DONE reuses the reload value.
    do_start();
    checks++; if (out !== 8'd5 || state_o !== ST_RUN || done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL done_restart out=%0d state=%0d done=%b busy=%b exp 5/1/0/1", out, state_o, done, busy); end
    tick();
    checks++; if (out !== 8'd4) begin errors++; $display("FAIL done_restart_dec got=%0d exp=4", out); end
  endtask

  task automatic test_pause();
    do_load(8'd10);
    do_start();
    repeat (3) tick();
    checks++; if (out !== 8'd7) begin errors++; $display("FAIL pause_pre got=%0d exp=7", out); end
    pause_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out !== 8'd7 || state_o !== ST_PAUSE || busy !== 1'b1 || borrow !== 1'b0) begin
        errors++; $display("FAIL pause_hold out=%0d state=%0d busy=%b borrow=%b exp 7/2/1/0", out, state_o, busy, borrow);
      end
    end
    pause_in = 1'b0;
    tick();
    checks++; if (out !== 8'd7 || state_o !== ST_RUN) begin errors++; $display("FAIL pause_resume out=%0d state=%0d exp 7/1", out, state_o); end
    tick();
    checks++; if (out !== 8'd6) begin errors++; $display("FAIL pause_dec1 got=%0d exp=6", out); end
    tick();
    checks++; if (out !== 8'd5) begin errors++; $display("FAIL pause_dec2 got=%0d exp=5", out); end
  endtask

  task automatic test_zero_limit();
    do_load(8'd0);
    do_start();
    for (int i = 0; i < 4; i++) begin
      checks++; if (out !== 8'd0 || state_o !== ST_IDLE || busy !== 1'b0 || borrow !== 1'b0 || done !== 1'b0) begin
        errors++; $display("FAIL zero_limit out=%0d state=%0d busy=%b borrow=%b done=%b exp all 0", out, state_o, busy, borrow, done);
      end
      tick();
    end
  endtask

  task automatic test_load_priority();
    int borrow_seen;
    borrow_seen = 0;
    do_load(8'd200);
    do_start();
    for (int i = 0; i < 50; i++) begin
      tick();
      if (borrow === 1'b1) borrow_seen++;
    end
    checks++; if (out !== 8'd150) begin errors++; $display("FAIL prio_pre got=%0d exp=150", out); end
    limit = 8'd20; load_in = 1'b1; start_in = 1'b1; pause_in = 1'b1;
    tick();
    load_in = 1'b0; start_in = 1'b0; pause_in = 1'b0;
    if (borrow === 1'b1) borrow_seen++;
    checks++; if (out !== 8'd20 || state_o !== ST_IDLE || busy !== 1'b0) begin errors++; $display("FAIL prio_load out=%0d state=%0d busy=%b exp 20/0/0", out, state_o, busy); end
    tick();
    if (borrow === 1'b1) borrow_seen++;
    checks++; if (out !== 8'd20 || state_o !== ST_IDLE) begin errors++; $display("FAIL prio_hold out=%0d state=%0d exp 20/0", out, state_o); end
    checks++; if (borrow_seen !== 0) begin errors++; $display("FAIL prio_borrow got=%0d pulses exp=0", borrow_seen); end
  endtask

  task automatic test_restart_over_pause();
    do_load(8'd8);
    do_start();
    repeat (2) tick();
    checks++; if (out !== 8'd6) begin errors++; $display("FAIL restart_pre got=%0d exp=6", out); end
    start_in = 1'b1; pause_in = 1'b1;
    tick();
    start_in = 1'b0; pause_in = 1'b0;
    checks++; if (out !== 8'd8 || state_o !== ST_RUN) begin errors++; $display("FAIL restart out=%0d state=%0d exp 8/1", out, state_o); end
    tick();
    checks++; if (out !== 8'd7) begin errors++; $display("FAIL restart_dec got=%0d exp=7", out); end
  endtask

  task automatic test_max_limit();
    do_load(8'd255);
    do_start();
    checks++; if (out !== 8'd255) begin errors++; $display("FAIL max_start got=%0d exp=255", out); end
    tick();
    checks++; if (out !== 8'd254 || borrow !== 1'b0) begin errors++; $display("FAIL max_dec out=%0d borrow=%b exp 254/0", out, borrow); end
  endtask

  task automatic test_async_reset();
    do_load(8'd5);
    do_start();
    repeat (2) tick();
    checks++; if (out !== 8'd3) begin errors++; $display("FAIL areset_pre got=%0d exp=3", out); end
    #2 rst_in = 1'b1;
    #1;
    checks++; if (out !== 8'd0 || busy !== 1'b0 || borrow !== 1'b0 || state_o !== ST_IDLE) begin
      errors++; $display("FAIL areset_async out=%0d busy=%b borrow=%b state=%0d exp 0/0/0/0", out, busy, borrow, state_o);
    end
    tick();
    #2 rst_in = 1'b0;
    do_load(8'd9);
    checks++; if (out !== 8'd9 || state_o !== ST_IDLE) begin errors++; $display("FAIL areset_first_load out=%0d state=%0d exp 9/0", out, state_o); end
    // A start right after a reset with reload cleared stays idle.
    rst_in = 1'b1; #2 rst_in = 1'b0;
    do_start();
    checks++; if (out !== 8'd0 || state_o !== ST_IDLE || busy !== 1'b0) begin errors++; $display("FAIL areset_start_zero out=%0d state=%0d busy=%b exp 0/0/0", out, state_o, busy); end
  endtask

  initial begin
    test_reset();
    test_basic_countdown();
    test_pause();
    test_zero_limit();
    test_load_priority();
    test_restart_over_pause();
    test_max_limit();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
